scan_cmd_sequencer: RTL and testbench
=====================================

Name: scan_cmd_sequencer

Overview:
- Host-side command front end sitting directly upstream of the scan chain controller.
- Accepts a byte command stream, drives the controller's design-select and input vector, and counts controller round boundaries (ready pulses) to know when results are valid.
- Returns a one-byte response per command.
- Supplies single-step design clocking by toggling input bit 0 across scan rounds.

Parameters:
- NUM_DESIGNS, 4: designs on chain; a select value >= NUM_DESIGNS is rejected.
- SETTLE_ROUNDS, 2: ready pulses to wait after an input change before outputs reflect it.
- ACK_BYTE, 8'hA5: success response.
- ERR_BYTE, 8'hEE: error response.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_data  in  8  command/argument byte
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  byte accepted when cmd_valid&cmd_ready at posedge
- rsp_data  out  8  response byte
- rsp_valid  out  1  response pending
- rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at posedge
- active_select  out  9  to controller, registered
- inputs  out  8  to controller, registered
- ctrl_outputs  in  8  controller outputs
- ctrl_ready  in  1  controller round-boundary pulse, 1 cycle per round

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset values: active_select=0, inputs=0, rsp_valid=0, rsp_data=0, cmd_ready=0 during reset, state=IDLE.
- Reset mid-command aborts the command; any pending response is dropped.

Commands (first byte = opcode):
- 0x01 SELECT hi lo: sel={hi[0],lo}.
  - sel<NUM_DESIGNS: active_select<=sel, reply ACK.
  - Otherwise: reply ERR, active_select unchanged.
  - hi[7:1] is ignored.
- 0x02 WRITE d: inputs<=d, reply ACK.
- 0x03 READ: wait SETTLE_ROUNDS ctrl_ready pulses, then sample ctrl_outputs the cycle after the last pulse; reply with the sampled byte.
- 0x04 CLOCK n: repeat n times: inputs[0]<=1, wait 1 pulse, inputs[0]<=0, wait 1 pulse; then reply ACK.
  - n=0 replies ACK immediately.
  - inputs[7:1] are untouched.
- Any other opcode: 1 byte consumed, reply ERR.

States: IDLE, ARG, WAIT, SAMPLE, CLK_HI, CLK_LO, RESP.
- IDLE: cmd_ready=1. On accept, latch the opcode.
  - 0x01/0x02/0x04 -> ARG.
  - 0x03 -> WAIT.
  - Other -> RESP.
- ARG: cmd_ready=1; collects 2 args (SELECT) or 1 arg (WRITE, CLOCK) with an arg counter.
  - After the last arg: SELECT/WRITE -> RESP; CLOCK -> CLK_HI if n!=0, else RESP.
- WAIT: pulse counter increments on each ctrl_ready; at count SETTLE_ROUNDS -> SAMPLE.
- SAMPLE: rsp_data<=ctrl_outputs -> RESP.
- CLK_HI / CLK_LO: drive inputs[0] as above; each state ends on one qualifying pulse.
  - Remaining-count decrements on leaving CLK_LO; -> RESP at 0.
- RESP: rsp_valid=1, rsp_data stable; on rsp_ready -> IDLE.
  - cmd_ready=0 in all states except IDLE/ARG, so commands never overlap.

Pulse qualification:
- A ctrl_ready pulse counts only if it occurs strictly after the cycle in which the state/inputs register was updated.
- A pulse coinciding with the update cycle is ignored: the controller sampled the old inputs that cycle.
- Pulses outside WAIT/CLK states are ignored.

Counters:
- Pulse counter is ceil(log2(SETTLE_ROUNDS+1)) bits, cleared on state entry.
- CLOCK remaining-count is 8 bits; n=255 supported.
- No wrap-around is possible.

Back-pressure:
- rsp_ready low holds RESP indefinitely; ctrl pulses during RESP are ignored.
- rsp_ready high on the same cycle rsp_valid rises completes the handshake that cycle; IDLE follows next cycle.

Latency:
- Byte accept to RESP entry is 1 cycle for SELECT/WRITE/error.
- READ latency = time to SETTLE_ROUNDS qualifying pulses + 2 cycles.

Test Plan:
- After reset, send 0x01,0x00,0x02 -> rsp 0xA5, active_select=9'd2. Then send 0x01,0x00,0x04 -> rsp 0xEE, active_select stays 2.
- Send 0x01,0x01,0x05 with NUM_DESIGNS=300 -> ACK, active_select=9'h105 (hi bit 0 used, hi[7:1] ignored).
- WRITE 0x3C, then READ against controller+chain model where the design echoes inputs -> inputs=0x3C; rsp=0x3C returned exactly one cycle after the 2nd qualifying pulse, never earlier.
- WRITE 0x80, then CLOCK 3 -> inputs[0] sequence 1,0,1,0,1,0, each level held across exactly one ready pulse; inputs[7:1]=0x40 throughout; rsp ACK after 6 pulses. CLOCK 0 -> immediate ACK, inputs unchanged.
- Opcode 0x7F -> rsp 0xEE; next byte 0x02,0x11 parsed as a WRITE. Hold rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
- Assert reset during READ WAIT (after 1 pulse) -> next cycle: rsp_valid=0, active_select=0, inputs=0, state IDLE. A fresh READ then requires 2 new pulses.

Source files
------------

// File: rtl/scan_cmd_sequencer.sv
// rtl/scan_cmd_sequencer.sv - byte command front end for the scan chain controller
// Parses SELECT/WRITE/READ/CLOCK commands and paces them on controller ready pulses.
module scan_cmd_sequencer #(
    parameter int unsigned NUM_DESIGNS   = 4,
    parameter int unsigned SETTLE_ROUNDS = 2,
    parameter logic [7:0]  ACK_BYTE      = 8'hA5,
    parameter logic [7:0]  ERR_BYTE      = 8'hEE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [8:0] active_select,
    output logic [7:0] inputs,
    input  logic [7:0] ctrl_outputs,
    input  logic       ctrl_ready
);

    localparam int PW = (SETTLE_ROUNDS < 1) ? 1 : $clog2(SETTLE_ROUNDS + 1);
    localparam logic [PW-1:0] LAST_PULSE = PW'((SETTLE_ROUNDS < 1) ? 0 : SETTLE_ROUNDS - 1);

    localparam logic [7:0] OP_SELECT = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_CLOCK  = 8'h04;

    typedef enum logic [2:0] {
        IDLE,
        ARG,
        WAIT,
        SAMPLE,
        CLK_HI,
        CLK_LO,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    opcode_q, opcode_d;
    logic          arg_cnt_q, arg_cnt_d;
    logic          hi_q, hi_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [7:0]    rem_q, rem_d;
    logic [8:0]    sel_q, sel_d;
    logic [7:0]    inputs_q, inputs_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          cmd_ready_c;
    logic          rsp_valid_c;
    logic [8:0]    sel_w;

    assign sel_w = {hi_q, cmd_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            opcode_q    <= 8'h00;
            arg_cnt_q   <= 1'b0;
            hi_q        <= 1'b0;
            pulse_cnt_q <= '0;
            rem_q       <= 8'h00;
            sel_q       <= 9'h000;
            inputs_q    <= 8'h00;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            arg_cnt_q   <= arg_cnt_d;
            hi_q        <= hi_d;
            pulse_cnt_q <= pulse_cnt_d;
            rem_q       <= rem_d;
            sel_q       <= sel_d;
            inputs_q    <= inputs_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Pulses are only looked at in WAIT/CLK states, so a pulse on the edge that
    // updates inputs (the controller saw the old value) is never counted.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        arg_cnt_d   = arg_cnt_q;
        hi_d        = hi_q;
        pulse_cnt_d = pulse_cnt_q;
        rem_d       = rem_q;
        sel_d       = sel_q;
        inputs_d    = inputs_q;
        rsp_data_d  = rsp_data_q;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    opcode_d  = cmd_data;
                    arg_cnt_d = 1'b0;
                    case (cmd_data)
                        OP_SELECT, OP_WRITE, OP_CLOCK: state_d = ARG;
                        OP_READ: begin
                            pulse_cnt_d = '0;
                            state_d     = WAIT;
                        end
                        default: begin
                            rsp_data_d = ERR_BYTE;
                            state_d    = RESP;
                        end
                    endcase
                end
            end
            ARG: begin
                cmd_ready_c = 1'b1;
                if (cmd_valid) begin
                    if (opcode_q == OP_SELECT && !arg_cnt_q) begin
                        hi_d      = cmd_data[0];
                        arg_cnt_d = 1'b1;
                    end else begin
                        rsp_data_d = ACK_BYTE;
                        state_d    = RESP;
                        case (opcode_q)
                            OP_SELECT: begin
                                if ({23'd0, sel_w} < NUM_DESIGNS) sel_d = sel_w;
                                else rsp_data_d = ERR_BYTE;
                            end
                            OP_WRITE: inputs_d = cmd_data;
                            OP_CLOCK: begin
                                if (cmd_data != 8'h00) begin
                                    rem_d       = cmd_data;
                                    inputs_d[0] = 1'b1;
                                    pulse_cnt_d = '0;
                                    state_d     = CLK_HI;
                                end
                            end
                            default: rsp_data_d = ERR_BYTE;
                        endcase
                    end
                end
            end
            WAIT: begin
                if (ctrl_ready) begin
                    pulse_cnt_d = pulse_cnt_q + 1'b1;
                    if (pulse_cnt_q == LAST_PULSE) state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                rsp_data_d = ctrl_outputs;
                state_d    = RESP;
            end
            CLK_HI: begin
                if (ctrl_ready) begin
                    inputs_d[0] = 1'b0;
                    state_d     = CLK_LO;
                end
            end
            CLK_LO: begin
                if (ctrl_ready) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        rsp_data_d = ACK_BYTE;
                        state_d    = RESP;
                    end else begin
                        inputs_d[0] = 1'b1;
                        state_d     = CLK_HI;
                    end
                end
            end
            RESP: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready     = cmd_ready_c & ~reset;
    assign rsp_valid     = rsp_valid_c & ~reset;
    assign rsp_data      = rsp_data_q;
    assign active_select = sel_q;
    assign inputs        = inputs_q;

endmodule

// File: tb/tb_scan_cmd_sequencer.sv
// tb/tb_scan_cmd_sequencer.sv - directed self-checking bench for scan_cmd_sequencer
module tb_scan_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] rsp_data;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [8:0] active_select;
    logic [7:0] inputs;
    logic [7:0] ctrl_outputs = 8'h00;
    logic       ctrl_ready = 1'b0;

    logic [7:0] c2_data = 8'h00;
    logic       c2_valid = 1'b0;
    logic       c2_ready;
    logic [7:0] r2_data;
    logic       r2_valid;
    logic [8:0] sel2;
    logic [7:0] in2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_cmd_sequencer u_dut (
        .clk(clk), .reset(reset),
        .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .active_select(active_select), .inputs(inputs),
        .ctrl_outputs(ctrl_outputs), .ctrl_ready(ctrl_ready)
    );

    scan_cmd_sequencer #(.NUM_DESIGNS(300)) u_dut300 (
        .clk(clk), .reset(reset),
        .cmd_data(c2_data), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
        .rsp_data(r2_data), .rsp_valid(r2_valid), .rsp_ready(1'b0),
        .active_select(sel2), .inputs(in2),
        .ctrl_outputs(8'h00), .ctrl_ready(1'b0)
    );

    // Controller + chain model: the design echoes its inputs, latched per round.
    always @(posedge clk) if (ctrl_ready) ctrl_outputs <= inputs;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse();
        ctrl_ready = 1'b1;
        tick();
        ctrl_ready = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [7:0] exp);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk(tag, {24'd0, rsp_data}, {24'd0, exp});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'h00);
        chk("rst_select", {23'd0, active_select}, 32'd0);
        chk("rst_inputs", {24'd0, inputs}, 32'd0);
        reset = 1'b0;
        #1;
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // SELECT 2 accepted, response one cycle after the last byte
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        chk("sel2_latency", {31'd0, rsp_valid}, 32'd1);
        chk("sel2_busy", {31'd0, cmd_ready}, 32'd0);
        chk("sel2_select", {23'd0, active_select}, 32'd2);
        get_rsp("sel2_rsp", 8'hA5);

        // SELECT 4 out of range
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        get_rsp("sel4_rsp", 8'hEE);
        chk("sel4_select", {23'd0, active_select}, 32'd2);

        // Wide chain: hi[0] used, hi[7:1] ignored
        c2_valid = 1'b1;
        c2_data = 8'h01; tick();
        c2_data = 8'hFF; tick();
        c2_data = 8'h05; tick();
        c2_valid = 1'b0;
        chk("sel300_valid", {31'd0, r2_valid}, 32'd1);
        chk("sel300_rsp", {24'd0, r2_data}, 32'hA5);
        chk("sel300_select", {23'd0, sel2}, 32'h105);

        // WRITE then READ; pulse coincident with the READ accept is ignored
        send_byte(8'h02); send_byte(8'h3C);
        get_rsp("wr3c_rsp", 8'hA5);
        chk("wr3c_inputs", {24'd0, inputs}, 32'h3C);
        cmd_data = 8'h03; cmd_valid = 1'b1; ctrl_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; ctrl_ready = 1'b0;
        pulse();
        tick();
        tick();
        chk("read_after1", {31'd0, rsp_valid}, 32'd0);
        chk("read_busy", {31'd0, cmd_ready}, 32'd0);
        pulse();
        chk("read_sample_cycle", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("read_one_after", {31'd0, rsp_valid}, 32'd1);
        get_rsp("read_rsp", 8'h3C);

        // CLOCK 3 toggling bit 0 with upper bits untouched
        send_byte(8'h02); send_byte(8'h80);
        get_rsp("wr80_rsp", 8'hA5);
        send_byte(8'h04); send_byte(8'h03);
        for (int i = 0; i < 3; i++) begin
            chk("clk_hi", {24'd0, inputs}, 32'h81);
            tick();
            chk("clk_hi_hold", {24'd0, inputs}, 32'h81);
            pulse();
            chk("clk_lo", {24'd0, inputs}, 32'h80);
            chk("clk_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
            chk("clk_lo_hold", {24'd0, inputs}, 32'h80);
            pulse();
        end
        chk("clk3_done", {31'd0, rsp_valid}, 32'd1);
        get_rsp("clk3_rsp", 8'hA5);
        chk("clk3_inputs", {24'd0, inputs}, 32'h80);

        send_byte(8'h04); send_byte(8'h00);
        chk("clk0_immediate", {31'd0, rsp_valid}, 32'd1);
        get_rsp("clk0_rsp", 8'hA5);
        chk("clk0_inputs", {24'd0, inputs}, 32'h80);

        // Unknown opcode, then back-pressure with stray pulses
        send_byte(8'h7F);
        chk("bad_immediate", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            ctrl_ready = (i % 3 == 0);
            tick();
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", {24'd0, rsp_data}, 32'hEE);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        ctrl_ready = 1'b0;
        get_rsp("bad_rsp", 8'hEE);

        // WRITE after error with rsp_ready already high
        rsp_ready = 1'b1;
        send_byte(8'h02); send_byte(8'h11);
        chk("wr11_valid", {31'd0, rsp_valid}, 32'd1);
        chk("wr11_rsp", {24'd0, rsp_data}, 32'hA5);
        tick();
        rsp_ready = 1'b0;
        chk("wr11_done", {31'd0, rsp_valid}, 32'd0);
        chk("wr11_idle", {31'd0, cmd_ready}, 32'd1);
        chk("wr11_inputs", {24'd0, inputs}, 32'h11);

        // Reset in the middle of READ WAIT
        send_byte(8'h03);
        pulse();
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_select", {23'd0, active_select}, 32'd0);
        chk("mid_rst_inputs", {24'd0, inputs}, 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_rst_idle", {31'd0, cmd_ready}, 32'd1);
        send_byte(8'h03);
        pulse();
        tick();
        chk("fresh_after1", {31'd0, rsp_valid}, 32'd0);
        pulse();
        tick();
        chk("fresh_ready", {31'd0, rsp_valid}, 32'd1);
        get_rsp("fresh_rsp", 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
